// File: rtl/if_pc_gen.sv
// if_pc_gen: IF-stage program-counter generator.
// Holds the fetch PC, advances it by 4, and applies hazard stalls and EX redirects.
// It traps misaligned or out-of-range fetch addresses before they reach instruction memory.
// Optional feature macro: IF_PERF_CNT_EN adds the perf_fetch_cnt and perf_redirect_cnt counters.
module if_pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_RANGE      = 2'b10;

    // The range check uses 33 bits, so pc+4 wrapping past 32'hFFFF_FFFC counts as out of range.
    localparam logic [32:0] LAST_ADDR = 33'(IMEM_WORDS) * 33'd4 - 33'd4;

    state_t      state_q, state_d;
    // Only the word index is stored, so pc[1:0] is zero by construction.
    logic [29:0] pc_word_q, pc_word_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] addr_q, addr_d;

    logic [32:0] seq_sum;
    logic        seq_out_of_range;
    logic        tgt_misaligned;
    logic        tgt_out_of_range;
    logic        tgt_legal;
    logic [1:0]  tgt_cause;
    logic        take_redirect;

    // Address arithmetic and legality checks for both the sequential and the redirect paths.
    always_comb begin
        seq_sum          = {1'b0, pc} + 33'd4;
        seq_out_of_range = seq_sum > LAST_ADDR;
        tgt_misaligned   = redirect_target[1:0] != 2'b00;
        tgt_out_of_range = {1'b0, redirect_target} > LAST_ADDR;
        tgt_legal        = !tgt_misaligned && !tgt_out_of_range;
        // Misalignment is reported ahead of the range check when both apply.
        tgt_cause        = tgt_misaligned ? CAUSE_MISALIGNED : CAUSE_RANGE;
    end

    // Next-state logic. Redirects take priority over stalls, and stalls take priority over sequential fetch.
    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d       = state_q;
        pc_word_d     = pc_word_q;
        cause_d       = cause_q;
        addr_d        = addr_q;
        take_redirect = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_en) begin
                    if (tgt_legal) begin
                        pc_word_d     = redirect_target[31:2];
                        take_redirect = 1'b1;
                    end else begin
                        state_d = FAULT;
                        addr_d  = redirect_target;
                        cause_d = tgt_cause;
                    end
                end else if (!stall) begin
                    if (seq_out_of_range) begin
                        state_d = FAULT;
                        addr_d  = seq_sum[31:0];
                        cause_d = CAUSE_RANGE;
                    end else begin
                        pc_word_d = seq_sum[31:2];
                    end
                end
            end
            FAULT: begin
                if (redirect_en) begin
                    if (tgt_legal) begin
                        state_d       = RUN;
                        pc_word_d     = redirect_target[31:2];
                        cause_d       = CAUSE_NONE;
                        addr_d        = 32'h0;
                        take_redirect = 1'b1;
                    end else begin
                        addr_d  = redirect_target;
                        cause_d = tgt_cause;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and fault registers. A synchronous reset overrides all other inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments ensure every register samples the pre-edge values.
        if (rst) begin
            state_q   <= BOOT;
            pc_word_q <= RESET_PC[31:2];
            cause_q   <= CAUSE_NONE;
            addr_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_word_q <= pc_word_d;
            cause_q   <= cause_d;
            addr_q    <= addr_d;
        end
    end

    assign pc          = {pc_word_q, 2'b00};
    assign pc_plus4    = seq_sum[31:0];
    // During a redirect, the stall is dropped for that cycle.
    assign fetch_valid = (state_q == RUN) && (!stall || redirect_en);
    assign fault       = (state_q == FAULT);
    assign fault_cause = cause_q;
    assign fault_addr  = addr_q;

`ifdef IF_PERF_CNT_EN
    // Performance counters. Both wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'h0;
            perf_redirect_cnt <= 32'h0;
        end else begin
            if (fetch_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (take_redirect) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// tb_if_pc_gen: self-checking bench for if_pc_gen.
// Directed scenarios are followed by randomized traffic, all compared against an address-level reference model.
module tb_if_pc_gen;

    localparam int    IMEM_WORDS = 1024;
    localparam longint LAST      = longint'(IMEM_WORDS) * 4 - 4;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] pc, pc_plus4, fault_addr;
    logic        fetch_valid, fault;
    logic [1:0]  fault_cause;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    int          m_mode  = M_BOOT;
    longint      m_pc    = 0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_fcnt  = 32'h0;
    logic [31:0] m_rcnt  = 32'h0;

    if_pc_gen #(.RESET_PC(32'h0), .IMEM_WORDS(IMEM_WORDS)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_en(redirect_en),
        .redirect_target(redirect_target),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid),
        .fault(fault),
        .fault_cause(fault_cause),
        .fault_addr(fault_addr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) <= LAST);
    endfunction

    // Model: advance one clock edge, applying the rules at the address level.
    task automatic model_edge(input logic r, input logic s, input logic re, input logic [31:0] t);
        bit fv;
        fv = (m_mode == M_RUN) && (!s || re);
        if (r) begin
            m_mode = M_BOOT; m_pc = 0; m_cause = 2'b00; m_addr = 32'h0;
            m_fcnt = 32'h0;  m_rcnt = 32'h0;
            return;
        end
        if (fv) m_fcnt = m_fcnt + 32'd1;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if (re) begin
                    if (legal(t)) begin
                        m_pc = t; m_rcnt = m_rcnt + 32'd1;
                    end else begin
                        m_mode = M_FAULT; m_addr = t;
                        m_cause = (t % 4 != 0) ? 2'b01 : 2'b10;
                    end
                end else if (!s) begin
                    if (m_pc + 4 > LAST) begin
                        m_mode = M_FAULT; m_addr = 32'(m_pc + 4); m_cause = 2'b10;
                    end else begin
                        m_pc = m_pc + 4;
                    end
                end
            end
            default: begin
                if (re) begin
                    if (legal(t)) begin
                        m_mode = M_RUN; m_pc = t; m_cause = 2'b00; m_addr = 32'h0;
                        m_rcnt = m_rcnt + 32'd1;
                    end else begin
                        m_addr = t;
                        m_cause = (t % 4 != 0) ? 2'b01 : 2'b10;
                    end
                end
            end
        endcase
    endtask

    // Drive one cycle's inputs, check all outputs against the model, then take the edge.
    task automatic step(input logic r, input logic s, input logic re, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; redirect_en = re; redirect_target = t;
        #1;
        check("pc", pc, 32'(m_pc));
        check("pc_plus4", pc_plus4, 32'(m_pc + 4));
        check("fetch_valid", 32'(fetch_valid), 32'((m_mode == M_RUN) && (!s || re)));
        check("fault", 32'(fault), 32'(m_mode == M_FAULT));
        check("fault_cause", 32'(fault_cause), 32'(m_cause));
        if (m_mode == M_FAULT) check("fault_addr", fault_addr, m_addr);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
        check("perf_redirect_cnt", perf_redirect_cnt, m_rcnt);
`endif
        @(posedge clk);
        model_edge(r, s, re, t);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] w;
        w = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
        case ($urandom_range(0, 4))
            0:       return w;
            1:       return w | 32'($urandom_range(1, 3));
            2:       return ($urandom | 32'h1000) & ~32'h3;
            3:       return $urandom | 32'h1001;
            default: return 32'(LAST) - (32'($urandom_range(0, 3)) << 2);
        endcase
    endfunction

    initial begin
        int guard;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset held, BOOT, then sequential fetch.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        #1 check("dir_pc_at_0x10", pc, 32'h10);

        // Stall for three cycles at 0x10.
        repeat (3) step(0, 1, 0, 0);
        #1 check("dir_stall_hold", pc, 32'h10);
        step(0, 0, 0, 0);
        #1 check("dir_resume", pc, 32'h14);
        repeat (3) step(0, 0, 0, 0);

        // A redirect combined with a stall: the redirect wins.
        step(0, 1, 1, 32'h40);
        #1 check("dir_redirect_pc", pc, 32'h40);
        check("dir_redirect_nofault", 32'(fault), 32'h0);
        step(0, 0, 0, 0);

        // A misaligned redirect faults; a legal redirect then recovers.
        step(0, 0, 1, 32'h42);
        #1 check("dir_mis_cause", 32'(fault_cause), 32'h1);
        check("dir_mis_addr", fault_addr, 32'h42);
        check("dir_mis_pc", pc, 32'h44);
        step(0, 1, 0, 0);
        step(0, 0, 1, 32'h100);
        #1 check("dir_recover_pc", pc, 32'h100);
        check("dir_recover_fault", 32'(fault), 32'h0);

        // Run to the last legal word, then fault on the range end.
        guard = 0;
        while (m_pc != LAST && guard < 2000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        check("dir_reach_end", 32'(m_pc == LAST), 32'h1);
        step(0, 0, 0, 0);
        #1 check("dir_end_fault", 32'(fault), 32'h1);
        check("dir_end_cause", 32'(fault_cause), 32'h2);
        check("dir_end_addr", fault_addr, 32'h1000);
        check("dir_end_pc", pc, 32'hFFC);

        // Reset applied while in FAULT.
        step(1, 0, 1, 32'h200);
        #1 check("dir_rst_pc", pc, 32'h0);
        check("dir_rst_fault", 32'(fault), 32'h0);

        // Ten sequential fetches plus two legal redirects.
        step(0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h80);
        repeat (5) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h300);
`ifdef IF_PERF_CNT_EN
        #1 check("dir_perf_fetch", perf_fetch_cnt, 32'd12);
        check("dir_perf_redir", perf_redirect_cnt, 32'd2);
        step(1, 0, 0, 0);
        #1 check("dir_perf_fetch_rst", perf_fetch_cnt, 32'd0);
        check("dir_perf_redir_rst", perf_redirect_cnt, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, s, re;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 9) == 0) || (m_mode == M_FAULT && $urandom_range(0, 2) == 0);
            step(r, s, re, rand_target());
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
